// File: rtl/n_output_controller.sv
// North output-port controller: latches the round-robin grant, streams one packet
// from the granted input into a registered north link, then advances the arbiter.
module n_output_controller #(
  parameter int FLIT_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              priority_to_cs_i,
  input  logic              priority_n_i,
  input  logic              priority_s_i,
  input  logic              priority_w_i,
  input  logic              priority_e_i,
  input  logic              priority_l_i,
  input  logic [FLIT_W-1:0] s_flit_i,
  input  logic [FLIT_W-1:0] w_flit_i,
  input  logic [FLIT_W-1:0] e_flit_i,
  input  logic [FLIT_W-1:0] l_flit_i,
  input  logic              s_valid_i,
  input  logic              w_valid_i,
  input  logic              e_valid_i,
  input  logic              l_valid_i,
  input  logic              s_tail_i,
  input  logic              w_tail_i,
  input  logic              e_tail_i,
  input  logic              l_tail_i,
  output logic              s_pop_o,
  output logic              w_pop_o,
  output logic              e_pop_o,
  output logic              l_pop_o,
  output logic [FLIT_W-1:0] n_flit_o,
  output logic              n_valid_o,
  output logic              n_tail_o,
  input  logic              n_ready_i,
  output logic              change_order_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_next;
  logic [1:0]        sel, sel_next, grant_idx;
  logic [CW-1:0]     cnt;
  logic [3:0]        grant, valid, tail, pop;
  logic [FLIT_W-1:0] flit_mux;
  logic              accept, tail_done, timeout, start, req_err;

  // Bit order matches the sel encoding: S=0, W=1, E=2, L=3.
  assign grant = {priority_l_i, priority_e_i, priority_w_i, priority_s_i};
  assign valid = {l_valid_i, e_valid_i, w_valid_i, s_valid_i};
  assign tail  = {l_tail_i, e_tail_i, w_tail_i, s_tail_i};

  always_comb begin
    case (sel)
      2'd0:    flit_mux = s_flit_i;
      2'd1:    flit_mux = w_flit_i;
      2'd2:    flit_mux = e_flit_i;
      default: flit_mux = l_flit_i;
    endcase
  end

  always_comb begin
    case (grant)
      4'b0010: grant_idx = 2'd1;
      4'b0100: grant_idx = 2'd2;
      4'b1000: grant_idx = 2'd3;
      default: grant_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_next = state;
    sel_next   = sel;
    pop        = '0;
    accept     = 1'b0;
    start      = 1'b0;
    req_err    = 1'b0;
    tail_done  = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (priority_to_cs_i) begin
          if (priority_n_i || ($countones(grant) > 1)) begin
            req_err = 1'b1;
          end else if ($onehot(grant) && valid[grant_idx]) begin
            start      = 1'b1;
            state_next = BUSY;
            sel_next   = grant_idx;
          end
        end
      end
      BUSY: begin
        accept   = valid[sel] & (~n_valid_o | n_ready_i);
        pop[sel] = accept;
        if (accept && tail[sel]) begin
          tail_done  = 1'b1;
          state_next = IDLE;
        end else if (!accept && (cnt == CW'(TIMEOUT - 1))) begin
          // The counter would reach TIMEOUT on this edge, so release now.
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign s_pop_o = pop[0];
  assign w_pop_o = pop[1];
  assign e_pop_o = pop[2];
  assign l_pop_o = pop[3];
  assign busy_o  = (state == BUSY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start || accept) begin
      cnt <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_valid_o <= 1'b0;
      n_tail_o  <= 1'b0;
      n_flit_o  <= '0;
    end else if (accept) begin
      n_valid_o <= 1'b1;
      n_tail_o  <= tail[sel];
      n_flit_o  <= flit_mux;
    end else if (n_ready_i) begin
      n_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      change_order_o <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      change_order_o <= tail_done | timeout;
      err_o          <= err_o | req_err | timeout;
    end
  end

endmodule

// File: tb/tb_n_output_controller.sv
// Bench for n_output_controller: directed packet scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the north port.
module tb_n_output_controller;
  localparam int FW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          priority_to_cs_i, priority_n_i, priority_s_i, priority_w_i, priority_e_i, priority_l_i;
  logic [FW-1:0] s_flit_i, w_flit_i, e_flit_i, l_flit_i;
  logic          s_valid_i, w_valid_i, e_valid_i, l_valid_i;
  logic          s_tail_i, w_tail_i, e_tail_i, l_tail_i;
  logic          s_pop_o, w_pop_o, e_pop_o, l_pop_o;
  logic [FW-1:0] n_flit_o;
  logic          n_valid_o, n_tail_o, n_ready_i, change_order_o, busy_o, err_o;

  always #5 clk = ~clk;

  n_output_controller #(.FLIT_W(FW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .priority_to_cs_i(priority_to_cs_i), .priority_n_i(priority_n_i),
    .priority_s_i(priority_s_i), .priority_w_i(priority_w_i),
    .priority_e_i(priority_e_i), .priority_l_i(priority_l_i),
    .s_flit_i(s_flit_i), .w_flit_i(w_flit_i), .e_flit_i(e_flit_i), .l_flit_i(l_flit_i),
    .s_valid_i(s_valid_i), .w_valid_i(w_valid_i), .e_valid_i(e_valid_i), .l_valid_i(l_valid_i),
    .s_tail_i(s_tail_i), .w_tail_i(w_tail_i), .e_tail_i(e_tail_i), .l_tail_i(l_tail_i),
    .s_pop_o(s_pop_o), .w_pop_o(w_pop_o), .e_pop_o(e_pop_o), .l_pop_o(l_pop_o),
    .n_flit_o(n_flit_o), .n_valid_o(n_valid_o), .n_tail_o(n_tail_o), .n_ready_i(n_ready_i),
    .change_order_o(change_order_o), .busy_o(busy_o), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-source input buffers: {tail, flit}; index S=0, W=1, E=2, L=3.
  logic [FW:0]   q[4][$];
  bit            gate[4];
  bit            g[4];
  bit            cs, gn, ready;
  bit            v[4], t[4];
  logic [FW-1:0] f[4];

  // Behavioural model of the port.
  bit            m_busy, m_nv, m_nt, m_co, m_err;
  int            m_src, m_cnt, last_pop;
  logic [FW-1:0] m_nf;

  // Observation logs.
  int          cyc = 0;
  logic [FW:0] dlog[$];
  int          co_cyc[$];
  int          wpop_cyc[$];
  int          busy_n;
  logic        smp_co, smp_valid;
  logic [FW-1:0] smp_flit;

  function automatic int model_pop();
    if (m_busy && v[m_src] && (!m_nv || ready)) return m_src;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_nv = 0; m_nt = 0; m_co = 0; m_err = 0;
    m_src = 0; m_cnt = 0; m_nf = '0; last_pop = -1;
  endtask

  task automatic model_step();
    int p, ng, gi;
    p  = model_pop();
    ng = 0;
    gi = 0;
    for (int i = 0; i < 4; i++) if (g[i]) begin ng++; gi = i; end
    m_co = 0;
    if (!m_busy) begin
      if (ready) m_nv = 0;
      if (cs) begin
        if (gn || ng > 1) m_err = 1;
        else if (ng == 1 && v[gi]) begin m_busy = 1; m_src = gi; m_cnt = 0; end
      end
    end else if (p >= 0) begin
      m_nv = 1; m_nf = f[p]; m_nt = t[p]; m_cnt = 0;
      if (t[p]) begin m_busy = 0; m_co = 1; end
    end else begin
      if (ready) m_nv = 0;
      m_cnt++;
      if (m_cnt == TO) begin m_busy = 0; m_err = 1; m_co = 1; end
    end
    last_pop = p;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      v[i] = gate[i] && (q[i].size() > 0);
      f[i] = (q[i].size() > 0) ? q[i][0][FW-1:0] : '0;
      t[i] = (q[i].size() > 0) ? q[i][0][FW] : 1'b0;
    end
    s_flit_i = f[0]; w_flit_i = f[1]; e_flit_i = f[2]; l_flit_i = f[3];
    s_valid_i = v[0]; w_valid_i = v[1]; e_valid_i = v[2]; l_valid_i = v[3];
    s_tail_i = t[0]; w_tail_i = t[1]; e_tail_i = t[2]; l_tail_i = t[3];
    priority_to_cs_i = cs; priority_n_i = gn;
    priority_s_i = g[0]; priority_w_i = g[1]; priority_e_i = g[2]; priority_l_i = g[3];
    n_ready_i = ready;
  endtask

  task automatic compare();
    int p;
    logic [3:0] pv, ep;
    p  = model_pop();
    pv = {l_pop_o, e_pop_o, w_pop_o, s_pop_o};
    ep = (p < 0) ? 4'b0 : 4'(1 << p);
    check("busy", busy_o, m_busy);
    check("pops", pv, ep);
    check("n_valid", n_valid_o, m_nv);
    check("n_tail", n_tail_o, m_nt);
    check("n_flit", n_flit_o, m_nf);
    check("change_order", change_order_o, m_co);
    check("err", err_o, m_err);
    if (n_valid_o && n_ready_i) dlog.push_back({n_tail_o, n_flit_o});
    if (change_order_o) co_cyc.push_back(cyc);
    if (w_pop_o) wpop_cyc.push_back(cyc);
    if (busy_o) busy_n++;
    smp_co = change_order_o; smp_valid = n_valid_o; smp_flit = n_flit_o;
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
    if (last_pop >= 0) void'(q[last_pop].pop_front());
    cs = 0; gn = 0;
    for (int i = 0; i < 4; i++) g[i] = 0;
    cyc++;
  endtask

  task automatic clear_logs();
    dlog.delete(); co_cyc.delete(); wpop_cyc.delete(); busy_n = 0;
  endtask

  // Called just after a rising edge; checks outputs while reset is held.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_nvalid"}, n_valid_o, 0);
    check({tag, "_ntail"}, n_tail_o, 0);
    check({tag, "_nflit"}, n_flit_o, 0);
    check({tag, "_co"}, change_order_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_pops"}, {l_pop_o, e_pop_o, w_pop_o, s_pop_o}, 0);
    model_reset();
    for (int i = 0; i < 4; i++) begin q[i].delete(); gate[i] = 1; end
    clear_logs();
    #1 reset = 1'b1;
  endtask

  initial begin
    int t0;
    logic [FW:0] e;
    reset = 1'b0;
    cs = 0; gn = 0; ready = 0;
    for (int i = 0; i < 4; i++) begin g[i] = 0; gate[i] = 1; end
    model_reset();
    drive();
    #2;
    check("rst_busy", busy_o, 0);
    check("rst_nvalid", n_valid_o, 0);
    check("rst_nflit", n_flit_o, 0);
    check("rst_co_err", {change_order_o, err_o}, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // W 4-flit packet, link always ready.
    do_reset("r1");
    ready = 1;
    for (int i = 0; i < 4; i++) q[1].push_back({1'(i == 3), FW'(32'hA0 + i)});
    t0 = cyc; cs = 1; g[1] = 1;
    for (int i = 0; i < 8; i++) tick();
    check("w_pop_count", wpop_cyc.size(), 4);
    if (wpop_cyc.size() == 4) begin
      check("w_pop_first", wpop_cyc[0], t0 + 1);
      check("w_pop_last", wpop_cyc[3], t0 + 4);
    end
    check("w_co_count", co_cyc.size(), 1);
    if (co_cyc.size() == 1) check("w_co_cycle", co_cyc[0], t0 + 5);
    check("w_dlog_size", dlog.size(), 4);
    for (int i = 0; i < 4 && i < dlog.size(); i++) begin
      e = {1'(i == 3), FW'(32'hA0 + i)};
      check("w_flit", dlog[i], e);
    end

    // Backpressure: three stalled cycles after the first flit shows.
    do_reset("r2");
    ready = 1;
    for (int i = 0; i < 4; i++) q[1].push_back({1'(i == 3), FW'(32'hB0 + i)});
    cs = 1; g[1] = 1;
    tick(); tick();
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_flit", smp_flit, 32'hB0);
      check("bp_hold_valid", smp_valid, 1);
    end
    check("bp_pops_during_stall", wpop_cyc.size(), 1);
    ready = 1;
    for (int i = 0; i < 6; i++) tick();
    check("bp_dlog_size", dlog.size(), 4);
    for (int i = 0; i < 4 && i < dlog.size(); i++) begin
      e = {1'(i == 3), FW'(32'hB0 + i)};
      check("bp_flit", dlog[i], e);
    end

    // Illegal grants.
    do_reset("r3");
    q[0].push_back({1'b1, 32'h11}); q[2].push_back({1'b1, 32'h22});
    cs = 1; g[0] = 1; g[2] = 1;
    tick();
    check("dual_err", err_o, 1);
    check("dual_busy", busy_o, 0);
    tick();
    do_reset("r4");
    q[0].push_back({1'b1, 32'h33});
    cs = 1; gn = 1;
    tick();
    check("uturn_err", err_o, 1);
    check("uturn_busy", busy_o, 0);
    tick();
    do_reset("r5");
    q[3].push_back({1'b1, 32'h44}); gate[3] = 0;
    cs = 1; g[3] = 1;
    tick();
    check("novalid_err", err_o, 0);
    check("novalid_busy", busy_o, 0);

    // Watchdog: L sends one non-tail flit, then goes quiet.
    do_reset("r6");
    ready = 1;
    q[3].push_back({1'b0, 32'hC0});
    t0 = cyc; cs = 1; g[3] = 1;
    for (int i = 0; i < 9; i++) tick();
    check("wd_co_count", co_cyc.size(), 1);
    if (co_cyc.size() == 1) check("wd_co_cycle", co_cyc[0], t0 + 6);
    check("wd_err", err_o, 1);
    check("wd_busy_cycles", busy_n, 5);
    check("wd_dlog_size", dlog.size(), 1);
    if (dlog.size() > 0) check("wd_flit", dlog[0], {1'b0, 32'hC0});

    // Back-to-back: S granted in the change_order cycle of an E packet.
    do_reset("r7");
    ready = 1;
    q[2].push_back({1'b0, 32'hE0}); q[2].push_back({1'b1, 32'hE1});
    q[0].push_back({1'b1, 32'h50});
    cs = 1; g[2] = 1;
    tick(); tick(); tick();
    cs = 1; g[0] = 1;
    tick();
    check("b2b_co", smp_co, 1);
    tick(); tick();
    check("b2b_valid", smp_valid, 1);
    check("b2b_flit", smp_flit, 32'h50);
    tick();

    // Reset in the middle of a stalled packet.
    do_reset("r8");
    ready = 0;
    q[1].push_back({1'b0, 32'hD0}); q[1].push_back({1'b1, 32'hD1});
    cs = 1; g[1] = 1;
    tick(); tick(); tick();
    check("mid_pre_busy", busy_o, 1);
    check("mid_pre_valid", n_valid_o, 1);
    do_reset("mid");
    for (int i = 0; i < 4; i++) tick();
    check("mid_no_co", co_cyc.size(), 0);

    // Randomized traffic.
    do_reset("r9");
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (q[i].size() < 4 && $urandom_range(0, 1) == 1)
          q[i].push_back({1'($urandom_range(0, 3) == 0), FW'($urandom)});
        gate[i] = ($urandom_range(0, 9) < 8);
      end
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        int r;
        cs = 1;
        r = $urandom_range(0, 59);
        if (r == 0) gn = 1;
        else if (r == 1) begin g[1] = 1; g[3] = 1; end
        else g[r % 4] = 1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
